// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Width of an index into n requesters; never zero so single-bit ports stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the per-grant beat counter; an unlimited burst still gets a 1-bit stub.
  function automatic int cnt_width(input int max_burst);
    return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);

  logic [N-1:0] rot;
  int           off;
  int           sum;

  // Rotate requests so ptr lands at bit 0, take the lowest set bit, then un-rotate the index.
  always_comb begin
    rot   = N'({req_i, req_i} >> ptr_i);
    any_o = |rot;
    off   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    sum = int'(ptr_i) + off;
    if (sum >= N) sum = sum - N;
    gnt_idx_o = IW'(sum);
    gnt_o     = '0;
    for (int k = 0; k < N; k++) begin
      gnt_o[k] = any_o && (sum == k);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-holding arbiter for the write port of a dual-clock FIFO.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ARB_IDLE | no grant; arbitration bubble, picks next requester if any
//  ARB_BUSY | grant held for one requester until LAST or burst cap
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 0
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ-1:0]            i_req_last,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [N_REQ-1:0]            o_req_ready,
  input  logic                        i_wr_full,
  output logic                        o_wr_en,
  output logic [DATA_WIDTH-1:0]       o_wr_data,
  output logic [N_REQ-1:0]            o_grant,
  output logic                        o_busy
);

  localparam int IW = idx_width(N_REQ);
  localparam int CW = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] CAP_LAST = (MAX_BURST > 0) ? CW'(MAX_BURST - 1) : '0;

  arb_state_e            state_q, state_d;
  logic [N_REQ-1:0]      grant_q, grant_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [N_REQ-1:0]      pick_gnt;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;

  logic                  busy;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept;
  logic                  cap_hit;
  logic                  rel;

  rr_pick #(.N(N_REQ)) u_rr_pick (
    .req_i     (i_req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (pick_gnt),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  // Select the granted requester's beat; one-hot grant makes this a plain AND-OR mux.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_q[k]) begin
        sel_valid = i_req_valid[k];
        sel_last  = i_req_last[k];
        sel_data  = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Handshake and FIFO-side outputs; full back-pressures combinationally.
  always_comb begin
    busy        = (state_q == ARB_BUSY);
    o_busy      = busy;
    o_grant     = grant_q;
    o_req_ready = (busy && !i_wr_full) ? grant_q : '0;
    o_wr_en     = busy && sel_valid && !i_wr_full;
    o_wr_data   = sel_data;
    accept      = o_wr_en;
    cap_hit     = (MAX_BURST != 0) && (cnt_q == CAP_LAST);
    rel         = accept && (sel_last || cap_hit);
  end

  // Next-state logic: grant on the idle bubble, hold through the packet, release once.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_BUSY;
          grant_d = pick_gnt;
          idx_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      ARB_BUSY: begin
        if (rel) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          cnt_d   = '0;
          ptr_d   = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        end else if (accept && (MAX_BURST != 0)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, grant, pointer and beat-count registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant is one-hot or empty, writes only happen under a held grant with room, busy mirrors grant.
  a_grant_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(o_grant));
  a_wr_legal:     assert property (@(posedge i_clk) disable iff (!i_rst_n) o_wr_en |-> (!i_wr_full && o_busy));
  a_busy_grant:   assert property (@(posedge i_clk) disable iff (!i_rst_n) o_busy == (|o_grant));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: capped instance for arbitration/hold/cap/full,
// unlimited-burst instance for async reset behaviour.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, rst0_n;
  logic [N-1:0]  valid, last;
  logic [N*DW-1:0] data;
  logic          full;

  logic [N-1:0]  ready, grant, ready0, grant0;
  logic          wr_en, busy, wr_en0, busy0;
  logic [DW-1:0] wr_data, wr_data0;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] log_q[$];
  logic [DW-1:0] exp_log [18] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0,
                                  8'h11, 8'h12, 8'h13, 8'h21,
                                  8'h01, 8'h02, 8'h03, 8'h04, 8'h1A,
                                  8'h05, 8'h06, 8'h07, 8'h08};
  logic [N-1:0]  exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [DW-1:0] exp_d [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (valid),
    .i_req_last  (last),
    .i_req_data  (data),
    .o_req_ready (ready),
    .i_wr_full   (full),
    .o_wr_en     (wr_en),
    .o_wr_data   (wr_data),
    .o_grant     (grant),
    .o_busy      (busy)
  );

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(0)) u_dut0 (
    .i_clk       (clk),
    .i_rst_n     (rst0_n),
    .i_req_valid (valid),
    .i_req_last  (last),
    .i_req_data  (data),
    .o_req_ready (ready0),
    .i_wr_full   (full),
    .o_wr_en     (wr_en0),
    .o_wr_data   (wr_data0),
    .o_grant     (grant0),
    .o_busy      (busy0)
  );

  // Record every beat the capped instance hands to the FIFO.
  always @(posedge clk) begin
    if (rst_n && wr_en) log_q.push_back(wr_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sd(input int k, input logic [DW-1:0] v);
    data[k*DW +: DW] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rst0_n = 1'b0;
    valid = '1; last = '1; full = 1'b0; data = '0;
    sd(0, 8'hA0); sd(1, 8'hA1); sd(2, 8'hA2); sd(3, 8'hA3);

    // Reset held with every requester valid
    tick(); tick(); #1;
    chk("rst_grant", grant, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Round-robin over single-beat packets, one idle cycle between grants
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      chk("rr_grant", grant, exp_g[i]);
      chk("rr_wr_data", wr_data, exp_d[i]);
      chk("rr_wr_en", wr_en, 1);
      tick(); #1;
      chk("rr_gap_grant", grant, 0);
      chk("rr_gap_wr_en", wr_en, 0);
    end

    // Packet hold: req1 three beats while req2 waits (pointer now 1)
    valid = 4'b0110; last = 4'b0000; sd(1, 8'h11); sd(2, 8'h21);
    tick(); #1;
    chk("hold_grant1", grant, 4'b0010);
    chk("hold_ready1", ready, 4'b0010);
    chk("hold_data1", wr_data, 8'h11);
    tick(); sd(1, 8'h12); #1;
    chk("hold_data2", wr_data, 8'h12);
    tick(); sd(1, 8'h13); last = 4'b0010; #1;
    chk("hold_data3", wr_data, 8'h13);
    chk("hold_grant3", grant, 4'b0010);
    tick(); valid = 4'b0100; last = 4'b0100; #1;
    chk("hold_rel_grant", grant, 0);
    tick(); #1;
    chk("hold_next_grant", grant, 4'b0100);
    chk("hold_next_data", wr_data, 8'h21);

    // Burst cap: req0 streams without LAST, req1 competes (pointer now 3)
    tick(); valid = 4'b0011; last = 4'b0010; sd(0, 8'h01); sd(1, 8'h1A); #1;
    chk("cap_idle_grant", grant, 0);
    tick(); #1;
    chk("cap_grant_b1", grant, 4'b0001);
    chk("cap_data_b1", wr_data, 8'h01);
    tick(); sd(0, 8'h02); #1;
    chk("cap_data_b2", wr_data, 8'h02);
    tick(); sd(0, 8'h03); #1;
    tick(); sd(0, 8'h04); #1;
    chk("cap_grant_b4", grant, 4'b0001);
    chk("cap_data_b4", wr_data, 8'h04);
    tick(); sd(0, 8'h05); #1;
    chk("cap_rel_grant", grant, 0);
    chk("cap_rel_busy", busy, 0);
    tick(); #1;
    chk("cap_other_grant", grant, 4'b0010);
    chk("cap_other_data", wr_data, 8'h1A);
    tick(); valid = 4'b0001; last = 4'b0000; #1;
    chk("cap_other_rel", grant, 0);
    tick(); #1;
    chk("cap_regrant", grant, 4'b0001);
    chk("cap_data_b5", wr_data, 8'h05);
    tick(); sd(0, 8'h06); #1;
    chk("cap_data_b6", wr_data, 8'h06);

    // Granted requester drops valid: grant held, nothing written
    tick(); valid = 4'b0000; #1;
    chk("vdrop_grant", grant, 4'b0001);
    chk("vdrop_wr_en", wr_en, 0);
    chk("vdrop_ready", ready, 4'b0001);
    tick(); #1;
    chk("vdrop_busy", busy, 1);

    // Full stall for three edges mid-packet
    valid = 4'b0001; sd(0, 8'h07); full = 1'b1; #1;
    chk("full_ready", ready, 0);
    chk("full_wr_en", wr_en, 0);
    tick(); #1;
    chk("full_ready2", ready, 0);
    chk("full_grant2", grant, 4'b0001);
    tick(); #1;
    chk("full_wr_en3", wr_en, 0);
    tick(); full = 1'b0; #1;
    chk("full_resume_wr_en", wr_en, 1);
    chk("full_resume_data", wr_data, 8'h07);
    chk("full_resume_ready", ready, 4'b0001);
    tick(); sd(0, 8'h08); #1;
    chk("full_grant_b8", grant, 4'b0001);
    chk("full_data_b8", wr_data, 8'h08);
    tick(); valid = 4'b0000; #1;
    chk("full_cap_rel", grant, 0);

    // Every accepted beat reached the FIFO exactly once and in order
    chk("log_len", log_q.size(), 18);
    for (int i = 0; i < 18; i++) begin
      if (i < log_q.size()) chk("log_beat", log_q[i], exp_log[i]);
    end

    // Unlimited burst instance: long packet then async reset mid-packet
    rst_n = 1'b0; valid = 4'b0100; last = 4'b0100; sd(2, 8'h31); rst0_n = 1'b1; #1;
    chk("main_async_rst", grant, 0);
    tick(); #1;
    chk("ub_grant2", grant0, 4'b0100);
    chk("ub_data2", wr_data0, 8'h31);
    tick(); valid = 4'b1000; last = 4'b0000; sd(3, 8'h41); #1;
    chk("ub_rel", grant0, 0);
    tick(); #1;
    chk("ub_grant3", grant0, 4'b1000);
    chk("ub_wr_en3", wr_en0, 1);
    repeat (5) tick();
    #1;
    chk("ub_long_grant", grant0, 4'b1000);
    chk("ub_long_busy", busy0, 1);
    #1 rst0_n = 1'b0;
    #1;
    chk("ub_arst_grant", grant0, 0);
    chk("ub_arst_busy", busy0, 0);
    chk("ub_arst_wr_en", wr_en0, 0);
    chk("ub_arst_ready", ready0, 0);
    valid = 4'b1111; last = 4'b1111;
    tick(); rst0_n = 1'b1; #1;
    chk("ub_rst_grant", grant0, 0);
    tick(); #1;
    chk("ub_ptr_reset", grant0, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
